rbn_norm: RTL and testbench
===========================

# rbn_norm

Range batch-normalization core for the training datapath. It buffers one mini-batch of activations and tracks the running sum, max and min. It then computes mean, range and a scaled reciprocal of the range, and streams x_hat = (x − mean)·SCALE/range one sample per cycle. The output feeds the gamma/beta adjust stage directly: x_hat_out and start_bn_tra_out drive that stage's x and start inputs.

## Interface
- DATA_WIDTH, 16, signed two's-complement sample width (Q(DATA_WIDTH−FRAC_BITS).FRAC_BITS)
- FRAC_BITS, 8, fractional bits of samples, SCALE, reciprocal and output
- MINI_BATCH, 64, samples per batch; power of two, ≥2
- ADDR_WIDTH, $clog2(MINI_BATCH), buffer index width
- SCALE, 16'h02E2, range-BN constant sqrt(2·ln n) in Q8.8 (≈2.884 for n=64); positive
- DIV_W, DATA_WIDTH+FRAC_BITS, reciprocal quotient width / divider cycle count

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- x_in  in  DATA_WIDTH  signed input sample
- x_valid_in  in  1  x_in valid
- x_ready_out  out  1  high in COLLECT; a sample is accepted on an edge where x_valid_in && x_ready_out
- x_hat_out  out  DATA_WIDTH  signed normalized sample, registered
- start_bn_tra_out  out  1  x_hat_out valid, registered
- mean_out  out  DATA_WIDTH  batch mean, held until next CALC
- range_out  out  DATA_WIDTH+1  unsigned max−min, held until next CALC
- busy_out  out  1  high in CALC, DIV, EMIT
- batch_done_out  out  1  one-cycle pulse coincident with the last output sample

## Operation
- States: COLLECT → CALC → DIV → EMIT → COLLECT.
- COLLECT:
  - Each accepted sample is written to buf[wr_cnt].
  - sum (DATA_WIDTH+ADDR_WIDTH signed) accumulates; max/min update.
  - The first sample of a batch initializes max and min.
  - wr_cnt wraps to 0 on the MINI_BATCH-th accept, and the state moves to CALC.
- CALC (1 cycle):
  - mean = sum >>> ADDR_WIDTH (arithmetic shift; floors).
  - range = max − min, computed in DATA_WIDTH+1 bits.
  - Divider loads dividend SCALE << FRAC_BITS and divisor range.
- DIV (DIV_W cycles): restoring divide, one quotient bit per cycle.
  - recip = quotient, reduced to DATA_WIDTH signed positive (see Configuration).
  - range == 0 forces recip = 0, so every output of the batch is 0.
- EMIT (MINI_BATCH cycles):
  - rd_cnt runs 0..MINI_BATCH−1 and reads buf[rd_cnt].
  - d = x − mean (DATA_WIDTH+1 signed).
  - p = d·recip (2·DATA_WIDTH+1 signed).
  - x_hat = p >>> FRAC_BITS, reduced to DATA_WIDTH.
  - Output order equals input order.
  - No downstream backpressure: the adjust stage is combinational.
- After the last emit, return to COLLECT; x_ready_out rises the next cycle.
- x_valid_in is ignored while x_ready_out is low.
- Reset (any time, including mid-batch or mid-emit): state = COLLECT; wr_cnt, rd_cnt, sum, max and min clear. Buffer contents are don't-care.

## Timing
- Reset values:
  - x_ready_out = 1.
  - x_hat_out, start_bn_tra_out, busy_out, batch_done_out = 0.
  - mean_out, range_out = 0.
- Let E0 be the edge accepting the last sample of a batch.
  - E0: x_ready_out falls and busy_out rises (both visible after E0).
  - E1: mean_out and range_out register.
  - E2..E(DIV_W+1): divider iterations.
  - E(DIV_W+2)..E(DIV_W+MINI_BATCH+1): start_bn_tra_out = 1, one new x_hat_out per edge.
  - batch_done_out is high with the final sample.
  - The edge after the final sample: start_bn_tra_out = 0, x_hat_out = 0, busy_out = 0, x_ready_out = 1.
- Default latency from E0 to first output: DIV_W+2 = 26 edges. Throughput: one batch per MINI_BATCH + DIV_W + 2 cycles, excluding collection.
- x_hat_out is forced to 0 whenever start_bn_tra_out is 0.

## Configuration
- RBN_SAT_EN defined:
  - recip saturates to 2^(DATA_WIDTH−1)−1.
  - x_hat saturates to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- RBN_SAT_EN undefined: both recip and x_hat keep their low DATA_WIDTH bits (wrap).

## Test plan
All tests use MINI_BATCH=4 and FRAC_BITS=8, with SCALE=16'h0100 unless stated; each output is checked at its exact cycle.
- Ramp: inputs 0x0100, 0x0200, 0x0300, 0x0400.
  - mean_out = 0x0280, range_out = 0x0300, recip = 0x0055.
  - Outputs 0xFF80, 0xFFD5, 0x002A, 0x007F.
  - First output DIV_W+2 edges after the last accept; batch_done_out is high with 0x007F only.
- Zero range: inputs 0x0500 ×4 → mean_out = 0x0500, range_out = 0, four outputs of 0x0000 with start_bn_tra_out high.
- Reciprocal saturation, SCALE=16'h7FFF: inputs 0, 1, 1, 1.
  - mean_out = 0, range_out = 1.
  - With RBN_SAT_EN: recip 0x7FFF, outputs 0, 0x007F, 0x007F, 0x007F.
  - Without RBN_SAT_EN: recip 0xFF00 (wrapped), outputs 0, 0xFFFF, 0xFFFF, 0xFFFF.
- Valid gaps and blocking: drive x_valid_in high only on alternate cycles → the same results as Ramp. x_valid_in held high during CALC/DIV/EMIT → nothing accepted.
- Mid-operation reset: assert rst_n low during the 2nd EMIT cycle.
  - All outputs return to reset values asynchronously.
  - The next batch runs the Ramp case correctly.
- Back-to-back batches: feed Ramp, then 0x0500 ×4 immediately when x_ready_out rises → both result sets are correct and no stale max/min carries over.

Source files
------------

// File: rtl/rbn_norm_if.sv
// rbn_norm_if: sample handshake plus normalized-output and status bundle of rbn_norm
interface rbn_norm_if #(
  parameter int DATA_WIDTH = 16
);
  logic signed [DATA_WIDTH-1:0] x_in;
  logic                         x_valid_in;
  logic                         x_ready_out;
  logic signed [DATA_WIDTH-1:0] x_hat_out;
  logic                         start_bn_tra_out;
  logic signed [DATA_WIDTH-1:0] mean_out;
  logic [DATA_WIDTH:0]          range_out;
  logic                         busy_out;
  logic                         batch_done_out;
  modport slave (
    input  x_in, x_valid_in,
    output x_ready_out, x_hat_out, start_bn_tra_out, mean_out, range_out, busy_out, batch_done_out
  );
  modport master (
    output x_in, x_valid_in,
    input  x_ready_out, x_hat_out, start_bn_tra_out, mean_out, range_out, busy_out, batch_done_out
  );
endinterface

// File: rtl/rbn_norm.sv
// rbn_norm: range batch-norm core; buffers a mini-batch, then streams (x-mean)*SCALE/range.
// Define RBN_SAT_EN to saturate the reciprocal and x_hat instead of keeping their low bits.
module rbn_norm #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    FRAC_BITS  = 8,
  parameter int                    MINI_BATCH = 64,
  parameter int                    ADDR_WIDTH = $clog2(MINI_BATCH),
  parameter logic [DATA_WIDTH-1:0] SCALE      = 16'h02E2,
  parameter int                    DIV_W      = DATA_WIDTH + FRAC_BITS
) (
  input logic      clk,
  input logic      rst_n,
  rbn_norm_if.slave bus
);
  localparam int SW = DATA_WIDTH + ADDR_WIDTH;
  localparam int RW = DATA_WIDTH + 2;
  localparam int CW = $clog2(DIV_W + 1);
  localparam int PW = 2 * DATA_WIDTH + 1;
  typedef enum logic [1:0] {COLLECT, CALC, DIV, EMIT} state_t;
  state_t r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_wr_cnt, r_rd_cnt;
  logic signed [SW-1:0] r_sum;
  logic signed [DATA_WIDTH-1:0] r_max, r_min, r_mean, r_xhat;
  logic signed [DATA_WIDTH-1:0] r_buf [MINI_BATCH];
  logic [DATA_WIDTH:0] r_range, r_rem, w_range;
  logic [DIV_W-1:0] r_quo;
  logic [CW-1:0] r_div_cnt;
  logic r_start, r_done;
  logic w_acc, w_emit;
  logic [RW-1:0] w_shift, w_trial;
  logic signed [DATA_WIDTH-1:0] w_x, w_recip, w_y;
  logic signed [DATA_WIDTH:0] w_d;
  logic signed [PW-1:0] w_p, w_sh;

  assign w_acc   = bus.x_valid_in && r_state == COLLECT;
  assign w_emit  = r_state == EMIT && !r_done;
  assign w_range = {r_max[DATA_WIDTH-1], r_max} - {r_min[DATA_WIDTH-1], r_min};
  assign w_shift = {r_rem, r_quo[DIV_W-1]};
  assign w_trial = w_shift - {1'b0, r_range};
  assign w_x     = r_buf[r_rd_cnt];
  assign w_d     = {w_x[DATA_WIDTH-1], w_x} - {r_mean[DATA_WIDTH-1], r_mean};
  assign w_p     = PW'(w_d) * PW'(w_recip);
  assign w_sh    = w_p >>> FRAC_BITS;

`ifdef RBN_SAT_EN
  assign w_recip = (r_range == '0) ? '0 :
                   (|r_quo[DIV_W-1:DATA_WIDTH-1]) ? {1'b0, {(DATA_WIDTH-1){1'b1}}} : r_quo[DATA_WIDTH-1:0];
  assign w_y = (&w_sh[PW-1:DATA_WIDTH-1] || ~|w_sh[PW-1:DATA_WIDTH-1]) ? w_sh[DATA_WIDTH-1:0] :
               w_sh[PW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
`else
  logic w_unused;
  assign w_recip  = (r_range == '0) ? '0 : r_quo[DATA_WIDTH-1:0];
  assign w_y      = w_sh[DATA_WIDTH-1:0];
  assign w_unused = ^w_sh[PW-1:DATA_WIDTH];
`endif

  assign bus.x_ready_out      = r_state == COLLECT;
  assign bus.busy_out         = r_state != COLLECT;
  assign bus.x_hat_out        = r_xhat;
  assign bus.start_bn_tra_out = r_start;
  assign bus.batch_done_out   = r_done;
  assign bus.mean_out         = r_mean;
  assign bus.range_out        = r_range;

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= COLLECT;
    else r_state <= w_next;

  // Next state; EMIT lingers one cycle after the last sample so busy covers it
  always_comb begin
    w_next = r_state;
    case (r_state)
      COLLECT: w_next = (w_acc && r_wr_cnt == ADDR_WIDTH'(MINI_BATCH - 1)) ? CALC : COLLECT;
      CALC:    w_next = DIV;
      DIV:     w_next = (r_div_cnt == CW'(DIV_W - 1)) ? EMIT : DIV;
      default: w_next = r_done ? COLLECT : EMIT;
    endcase
  end

  // Sample buffer; contents need no reset
  always_ff @(posedge clk)
    if (w_acc) r_buf[r_wr_cnt] <= bus.x_in;

  // Batch statistics; the first sample of a batch restarts sum, max and min
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_cnt <= '0;
      r_sum    <= '0;
      r_max    <= '0;
      r_min    <= '0;
    end else if (w_acc) begin
      r_wr_cnt <= r_wr_cnt + 1'b1;
      r_sum    <= (r_wr_cnt == '0) ? SW'(bus.x_in) : r_sum + SW'(bus.x_in);
      r_max    <= (r_wr_cnt == '0 || bus.x_in > r_max) ? bus.x_in : r_max;
      r_min    <= (r_wr_cnt == '0 || bus.x_in < r_min) ? bus.x_in : r_min;
    end

  // Mean/range capture and restoring divide of SCALE<<FRAC_BITS by range
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_mean    <= '0;
      r_range   <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_div_cnt <= '0;
    end else if (r_state == CALC) begin
      r_mean    <= DATA_WIDTH'(r_sum >>> ADDR_WIDTH);
      r_range   <= w_range;
      r_rem     <= '0;
      r_quo     <= {SCALE, {FRAC_BITS{1'b0}}};
      r_div_cnt <= '0;
    end else if (r_state == DIV) begin
      r_rem     <= w_trial[RW-1] ? w_shift[RW-2:0] : w_trial[RW-2:0];
      r_quo     <= {r_quo[DIV_W-2:0], ~w_trial[RW-1]};
      r_div_cnt <= r_div_cnt + 1'b1;
    end

  // Registered output stream in input order; x_hat is zero whenever not valid
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rd_cnt <= '0;
      r_start  <= 1'b0;
      r_done   <= 1'b0;
      r_xhat   <= '0;
    end else begin
      r_start  <= w_emit;
      r_done   <= w_emit && r_rd_cnt == ADDR_WIDTH'(MINI_BATCH - 1);
      r_xhat   <= w_emit ? w_y : '0;
      r_rd_cnt <= w_emit ? r_rd_cnt + 1'b1 : r_rd_cnt;
    end
endmodule

// File: tb/tb_rbn_norm.sv
// tb_rbn_norm: directed and randomized checks of rbn_norm against a behavioural model
module tb_rbn_norm;
  localparam int DW = 16, FB = 8, MB = 4, DIV_W = DW + FB;
  logic clk = 0, rst_n = 0;
  logic sel = 0, d_v = 0;
  logic [15:0] d_x = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  rbn_norm_if #(.DATA_WIDTH(DW)) ia ();
  rbn_norm_if #(.DATA_WIDTH(DW)) ib ();
  rbn_norm #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .MINI_BATCH(MB), .SCALE(16'h0100)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  rbn_norm #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .MINI_BATCH(MB), .SCALE(16'h7FFF)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));

  assign ia.x_in = d_x;
  assign ib.x_in = d_x;
  assign ia.x_valid_in = d_v && !sel;
  assign ib.x_valid_in = d_v && sel;

  logic [15:0] o_xhat, o_mean;
  logic [16:0] o_range;
  logic o_start, o_ready, o_busy, o_done;
  assign o_xhat  = sel ? ib.x_hat_out : ia.x_hat_out;
  assign o_mean  = sel ? ib.mean_out : ia.mean_out;
  assign o_range = sel ? ib.range_out : ia.range_out;
  assign o_start = sel ? ib.start_bn_tra_out : ia.start_bn_tra_out;
  assign o_ready = sel ? ib.x_ready_out : ia.x_ready_out;
  assign o_busy  = sel ? ib.busy_out : ia.busy_out;
  assign o_done  = sel ? ib.batch_done_out : ia.batch_done_out;

  logic signed [15:0] smp [MB];
  logic [15:0] e_y [MB];
  logic [15:0] e_mean;
  logic [16:0] e_range;

  logic [15:0] c_xhat [MB];
  logic c_start [MB];
  logic c_done [MB];
  logic [15:0] c_mean, c_tail_xhat;
  logic [16:0] c_range;
  logic c_e0_ok, c_timeout, c_tail_start, c_tail_busy, c_tail_ready, c_tail_done;
  int c_early;

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if (a % b != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint red16(input longint v);
`ifdef RBN_SAT_EN
    return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
`else
    longint t;
    t = v & 64'hFFFF;
    return t >= 32768 ? t - 65536 : t;
`endif
  endfunction

  task automatic model(input longint scale);
    longint sum, mx, mn, mean, rng, recip;
    sum = 0;
    mx = smp[0];
    mn = smp[0];
    for (int i = 0; i < MB; i++) begin
      sum += longint'(smp[i]);
      if (longint'(smp[i]) > mx) mx = smp[i];
      if (longint'(smp[i]) < mn) mn = smp[i];
    end
    mean = fdiv(sum, MB);
    rng = mx - mn;
    recip = rng == 0 ? 0 : red16((scale * 256) / rng);
    e_mean = 16'(mean);
    e_range = 17'(rng);
    for (int i = 0; i < MB; i++) e_y[i] = 16'(red16(fdiv((longint'(smp[i]) - mean) * recip, 256)));
  endtask

  task automatic set4(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
    smp[0] = a;
    smp[1] = b;
    smp[2] = c;
    smp[3] = d;
  endtask

  task automatic run_batch(input bit gaps, input bit hold, input int abort_k);
    int w;
    c_early = 0;
    c_timeout = 0;
    for (int i = 0; i < MB; i++) begin
      w = 0;
      while (!o_ready && w < 200) begin
        @(posedge clk); #1;
        w++;
      end
      if (w >= 200) c_timeout = 1;
      d_x = smp[i];
      d_v = 1;
      @(posedge clk); #1;
      if (gaps && i < MB - 1) begin
        d_v = 0;
        @(posedge clk); #1;
      end
    end
    d_v = hold;
    d_x = 16'h7FFF;
    c_e0_ok = !o_ready && o_busy;
    for (int k = 1; k <= DIV_W + MB + 2; k++) begin
      @(posedge clk); #1;
      if (k == abort_k) return;
      if (k == 1) begin
        c_mean = o_mean;
        c_range = o_range;
      end
      if (k <= DIV_W + 1 && o_start) c_early++;
      if (k >= DIV_W + 2 && k <= DIV_W + MB + 1) begin
        c_xhat[k-DIV_W-2] = o_xhat;
        c_start[k-DIV_W-2] = o_start;
        c_done[k-DIV_W-2] = o_done;
      end
      if (k == DIV_W + MB + 2) begin
        c_tail_start = o_start;
        c_tail_xhat = o_xhat;
        c_tail_busy = o_busy;
        c_tail_ready = o_ready;
        c_tail_done = o_done;
        d_v = 0;
      end
    end
  endtask

  task automatic test_batch(input string nm, input bit gaps, input bit hold);
    model(sel ? 64'h7FFF : 64'h0100);
    run_batch(gaps, hold, 0);
    checks++; if (c_timeout !== 0) begin errors++; $display("FAIL %s accept_timeout got %b exp 0", nm, c_timeout); end
    checks++; if (c_e0_ok !== 1) begin errors++; $display("FAIL %s e0_ready_busy got %b exp 1", nm, c_e0_ok); end
    checks++; if (c_mean !== e_mean) begin errors++; $display("FAIL %s mean got %h exp %h", nm, c_mean, e_mean); end
    checks++; if (c_range !== e_range) begin errors++; $display("FAIL %s range got %h exp %h", nm, c_range, e_range); end
    checks++; if (c_early !== 0) begin errors++; $display("FAIL %s early_start got %0d exp 0", nm, c_early); end
    for (int i = 0; i < MB; i++) begin
      checks++; if (c_start[i] !== 1) begin errors++; $display("FAIL %s start[%0d] got %b exp 1", nm, i, c_start[i]); end
      checks++; if (c_xhat[i] !== e_y[i]) begin errors++; $display("FAIL %s xhat[%0d] got %h exp %h", nm, i, c_xhat[i], e_y[i]); end
      checks++; if (c_done[i] !== (i == MB - 1)) begin errors++; $display("FAIL %s done[%0d] got %b exp %b", nm, i, c_done[i], i == MB - 1); end
    end
    checks++;
    if ({c_tail_start, c_tail_xhat, c_tail_busy, c_tail_ready, c_tail_done} !== {1'b0, 16'h0000, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL %s tail start/xhat/busy/ready/done got %b/%h/%b/%b/%b exp 0/0000/0/1/0", nm, c_tail_start, c_tail_xhat, c_tail_busy, c_tail_ready, c_tail_done);
    end
  endtask

  task automatic test_reset();
    sel = 0;
    d_v = 0;
    rst_n = 0;
    #12;
    checks++;
    if ({o_ready, o_start, o_xhat, o_busy, o_done, o_mean, o_range} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 17'h0}) begin
      errors++;
      $display("FAIL reset ready/start/xhat/busy/done/mean/range got %b/%b/%h/%b/%b/%h/%h exp 1/0/0000/0/0/0000/00000", o_ready, o_start, o_xhat, o_busy, o_done, o_mean, o_range);
    end
    rst_n = 1;
    @(posedge clk); #1;
    checks++; if (o_ready !== 1 || o_busy !== 0) begin errors++; $display("FAIL reset_idle ready/busy got %b/%b exp 1/0", o_ready, o_busy); end
  endtask

  task automatic test_ramp();
    sel = 0;
    set4(16'h0100, 16'h0200, 16'h0300, 16'h0400);
    test_batch("ramp", 0, 0);
    checks++; if (c_mean !== 16'h0280 || c_range !== 17'h0300) begin errors++; $display("FAIL ramp_const mean/range got %h/%h exp 0280/00300", c_mean, c_range); end
    checks++;
    if ({c_xhat[0], c_xhat[1], c_xhat[2], c_xhat[3]} !== {16'hFF80, 16'hFFD5, 16'h002A, 16'h007F}) begin
      errors++;
      $display("FAIL ramp_const outputs got %h %h %h %h exp ff80 ffd5 002a 007f", c_xhat[0], c_xhat[1], c_xhat[2], c_xhat[3]);
    end
  endtask

  task automatic test_zero_range();
    sel = 0;
    set4(16'h0500, 16'h0500, 16'h0500, 16'h0500);
    test_batch("zero_range", 0, 0);
    checks++; if (c_mean !== 16'h0500 || c_range !== 17'h0) begin errors++; $display("FAIL zero_range_const mean/range got %h/%h exp 0500/00000", c_mean, c_range); end
  endtask

  task automatic test_recip_sat();
    logic [15:0] exp1;
`ifdef RBN_SAT_EN
    exp1 = 16'h007F;
`else
    exp1 = 16'hFFFF;
`endif
    sel = 1;
    set4(16'h0000, 16'h0001, 16'h0001, 16'h0001);
    test_batch("recip_sat", 0, 0);
    checks++; if (c_xhat[0] !== 16'h0000 || c_xhat[3] !== exp1) begin errors++; $display("FAIL recip_sat_const x0/x3 got %h/%h exp 0000/%h", c_xhat[0], c_xhat[3], exp1); end
    sel = 0;
  endtask

  task automatic test_gaps_and_blocking();
    sel = 0;
    set4(16'h0100, 16'h0200, 16'h0300, 16'h0400);
    test_batch("gaps", 1, 0);
    test_batch("valid_held_busy", 0, 1);
    test_batch("after_held", 0, 0);
  endtask

  task automatic test_mid_reset();
    sel = 0;
    set4(16'h0100, 16'h0200, 16'h0300, 16'h0400);
    run_batch(0, 0, DIV_W + 2);
    checks++; if (o_start !== 1 || o_xhat !== 16'hFF80) begin errors++; $display("FAIL mid_reset_first start/xhat got %b/%h exp 1/ff80", o_start, o_xhat); end
    rst_n = 0;
    #1;
    checks++;
    if ({o_ready, o_start, o_xhat, o_busy, o_done, o_mean, o_range} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 17'h0}) begin
      errors++;
      $display("FAIL mid_reset ready/start/xhat/busy/done/mean/range got %b/%b/%h/%b/%b/%h/%h exp 1/0/0000/0/0/0000/00000", o_ready, o_start, o_xhat, o_busy, o_done, o_mean, o_range);
    end
    #2;
    rst_n = 1;
    #1;
    test_batch("ramp_after_reset", 0, 0);
  endtask

  task automatic test_back_to_back();
    sel = 0;
    set4(16'h0100, 16'h0200, 16'h0300, 16'h0400);
    test_batch("b2b_ramp", 0, 0);
    set4(16'h0500, 16'h0500, 16'h0500, 16'h0500);
    test_batch("b2b_const", 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      sel = n[0];
      for (int i = 0; i < MB; i++) smp[i] = (n < 4) ? 16'($urandom_range(0, 16'hFFFF)) : 16'($signed(16'($urandom_range(0, 16'h0FFF))) - 16'sh0800);
      test_batch($sformatf("random%0d", n), n[1], 0);
    end
    sel = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ramp();
    test_zero_range();
    test_recip_sat();
    test_gaps_and_blocking();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
